// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus scheduler: state encoding,
// init command bytes and the long-execution command decode.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;

  localparam logic [1:0] INIT_LAST_IDX = 2'd3;

  // Clear and home are the only commands with the long execution time.
  function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_sched_if.sv
// Requester handshakes plus LCD pin bundle between content logic, the
// scheduler and the display.
interface lcd_bus_sched_if;
  logic       REQ0_VALID;
  logic       REQ0_RS;
  logic [7:0] REQ0_DATA;
  logic       REQ0_READY;
  logic       REQ1_VALID;
  logic       REQ1_RS;
  logic [7:0] REQ1_DATA;
  logic       REQ1_READY;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic       INIT_DONE;
  logic       BUSY;

  modport master (
    output REQ0_VALID, REQ0_RS, REQ0_DATA, REQ1_VALID, REQ1_RS, REQ1_DATA,
    input  REQ0_READY, REQ1_READY, LCD_E, LCD_RS, LCD_RW, LCD_DATA,
           INIT_DONE, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_RS, REQ0_DATA, REQ1_VALID, REQ1_RS, REQ1_DATA,
    output REQ0_READY, REQ1_READY, LCD_E, LCD_RS, LCD_RW, LCD_DATA,
           INIT_DONE, BUSY
  );
endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted
// requester and only moves when the grant is actually taken.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (req[0] && (!req[1] || last_q)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
    if (accept && (gnt != '0)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// Write-only HD44780 bus scheduler: power-on init, then round-robin service
// of two byte requesters, each as one timed E strobe plus execution wait.
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON = 15000,
  parameter int unsigned T_SU      = 2,
  parameter int unsigned T_EW      = 4,
  parameter int unsigned T_H       = 2,
  parameter int unsigned T_CMD     = 40,
  parameter int unsigned T_LONG    = 1600
) (
  input  logic         CLK,
  input  logic         RESETN,
  lcd_bus_sched_if.slave bus
);

  localparam logic [15:0] PWR_M1  = 16'(T_POWERON - 1);
  localparam logic [15:0] SU_M1   = 16'(T_SU - 1);
  localparam logic [15:0] EW_M1   = 16'(T_EW - 1);
  localparam logic [15:0] H_M1    = 16'(T_H - 1);
  localparam logic [15:0] CMD_M1  = 16'(T_CMD - 1);
  localparam logic [15:0] LONG_M1 = 16'(T_LONG - 1);

  lcd_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic        long_q, long_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic [1:0]  gnt;

  lcd_rr_arb u_arb (
    .clk    (CLK),
    .rst_n  (RESETN),
    .req    ({bus.REQ1_VALID, bus.REQ0_VALID}),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    long_d      = long_q;
    rs_d        = rs_q;
    data_d      = data_q;
    ready_d     = '0;
    accept      = 1'b0;

    // Loading the next init byte happens on the PWR_WAIT/EXEC exit edge so
    // that init costs no cycles beyond the timed phases themselves.
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SETUP;
          cnt_d   = SU_M1;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = lcd_init_cmd(2'd0);
          long_d  = lcd_is_long(1'b0, lcd_init_cmd(2'd0));
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_E_HIGH;
          cnt_d   = EW_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_E_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = H_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_EXEC;
          cnt_d   = long_q ? LONG_M1 : CMD_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == INIT_LAST_IDX) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SU_M1;
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = lcd_init_cmd(idx_q + 2'd1);
            long_d  = lcd_is_long(1'b0, lcd_init_cmd(idx_q + 2'd1));
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_IDLE: begin
        if (ready_q != '0) begin
          state_d = ST_SETUP;
          cnt_d   = SU_M1;
          rs_d    = ready_q[1] ? bus.REQ1_RS   : bus.REQ0_RS;
          data_d  = ready_q[1] ? bus.REQ1_DATA : bus.REQ0_DATA;
          long_d  = lcd_is_long(rs_d, data_d);
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = PWR_M1;
      end
    endcase

    // Grant is registered so READY is high in the first IDLE cycle itself.
    if ((state_d == ST_IDLE) && init_done_d && (ready_q == '0)) begin
      accept  = 1'b1;
      ready_d = gnt;
    end

    e_d    = (state_d == ST_E_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= PWR_M1;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      long_q      <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      ready_q     <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      long_q      <= long_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.LCD_E      = e_q;
  assign bus.LCD_RS     = rs_q;
  assign bus.LCD_RW     = 1'b0;
  assign bus.LCD_DATA   = data_q;
  assign bus.REQ0_READY = ready_q[0];
  assign bus.REQ1_READY = ready_q[1];
  assign bus.INIT_DONE  = init_done_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Scoreboard bench for lcd_bus_sched: expected strobes are queued as
// stimulus is driven and checked as E pulses appear on the LCD bus.
module tb_lcd_bus_sched;
  import lcd_pkg::*;

  localparam int T_POWERON = 15000;
  localparam int T_SU      = 2;
  localparam int T_EW      = 4;
  localparam int T_H       = 2;
  localparam int T_CMD     = 40;
  localparam int T_LONG    = 1600;
  localparam int XFER      = T_SU + T_EW + T_H;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_sched_if bus ();

  lcd_bus_sched #(
    .T_POWERON (T_POWERON),
    .T_SU      (T_SU),
    .T_EW      (T_EW),
    .T_H       (T_H),
    .T_CMD     (T_CMD),
    .T_LONG    (T_LONG)
  ) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_rise;
  } xfer_t;

  xfer_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    ecnt = 0;
  int    last_ready = 0;
  int    rise_at = 0;
  int    both_cnt = 0;
  logic  prev_e = 1'b0;
  logic  rise_rs = 1'b0;
  logic [7:0] rise_data = '0;
  bit    skip_width = 1'b0;

  always @(posedge clk) ecnt <= resetn ? ecnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, ecnt);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input int er);
    xfer_t x;
    x.rs = rs;
    x.data = d;
    x.exp_rise = er;
    sb.push_back(x);
  endtask

  task automatic push_init();
    logic [7:0] cmds [4];
    cmds[0] = 8'h3C; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    for (int i = 0; i < 4; i++)
      push(1'b0, cmds[i], T_POWERON + T_SU + i * (XFER + T_CMD));
  endtask

  // Bus monitor: pops the scoreboard on every E rise.
  always @(negedge clk) begin
    if (bus.REQ0_READY && bus.REQ1_READY) both_cnt++;
    if (bus.REQ0_READY || bus.REQ1_READY) last_ready = ecnt;
    if (bus.LCD_E && !prev_e) begin
      rise_at   = ecnt;
      rise_rs   = bus.LCD_RS;
      rise_data = bus.LCD_DATA;
      chk("e_rise_expected", (sb.size() > 0), 1);
      chk("rw_low", bus.LCD_RW, 0);
      if (sb.size() > 0) begin
        xfer_t x;
        x = sb.pop_front();
        chk("strobe_rs", bus.LCD_RS, x.rs);
        chk("strobe_data", bus.LCD_DATA, x.data);
        chk("strobe_cycle", ecnt,
            (x.exp_rise >= 0) ? x.exp_rise : last_ready + 1 + T_SU);
      end
    end
    if (!bus.LCD_E && prev_e && !skip_width) begin
      chk("e_width", ecnt - rise_at, T_EW);
      chk("hold_rs", bus.LCD_RS, rise_rs);
      chk("hold_data", bus.LCD_DATA, rise_data);
    end
    prev_e = bus.LCD_E;
  end

  task automatic wait_ready(input int limit, output int who, output int at);
    bit seen;
    seen = 1'b0;
    who = -1;
    at = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.REQ0_READY || bus.REQ1_READY) begin
        seen = 1'b1;
        at = ecnt;
        who = (bus.REQ0_READY && bus.REQ1_READY) ? 2 : (bus.REQ1_READY ? 1 : 0);
      end
    end
  endtask

  task automatic wait_init_done(output int at, output int early);
    bit seen;
    seen = 1'b0;
    at = -1;
    early = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (bus.INIT_DONE) begin
        seen = 1'b1;
        at = ecnt;
      end else if (bus.REQ0_READY || bus.REQ1_READY) begin
        early++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_e"}, bus.LCD_E, 0);
    chk({pfx, "_rs"}, bus.LCD_RS, 0);
    chk({pfx, "_rw"}, bus.LCD_RW, 0);
    chk({pfx, "_data"}, bus.LCD_DATA, 0);
    chk({pfx, "_ready"}, {bus.REQ1_READY, bus.REQ0_READY}, 0);
    chk({pfx, "_init_done"}, bus.INIT_DONE, 0);
    chk({pfx, "_busy"}, bus.BUSY, 1);
  endtask

  initial begin
    int who, at, last_at, early;
    bus.REQ0_VALID = 1'b0; bus.REQ0_RS = 1'b0; bus.REQ0_DATA = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_RS = 1'b0; bus.REQ1_DATA = '0;
    resetn = 1'b0;
    @(negedge clk);
    // Requester 0 pending from reset onwards.
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h4B;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    push_init();
    push(1'b1, 8'h4B, -1);
    resetn = 1'b1;

    wait_init_done(at, early);
    chk("init_done_cycle", at, T_POWERON + 3 * (XFER + T_CMD) + XFER + T_LONG);
    chk("no_early_ready", early, 0);
    chk("ready0_first_idle", {bus.REQ1_READY, bus.REQ0_READY}, 2'b01);
    chk("busy_idle", bus.BUSY, 0);
    last_at = at;
    @(posedge clk); #1;
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b1; bus.REQ1_RS = 1'b0; bus.REQ1_DATA = 8'h01;
    push(1'b0, 8'h01, -1);

    wait_ready(200, who, at);
    chk("grant_ord", who, 1);
    chk("gap_ord", at - last_at, 1 + XFER + T_CMD);
    last_at = at;
    @(posedge clk); #1;
    bus.REQ1_DATA = 8'h80;
    push(1'b0, 8'h80, -1);

    wait_ready(2000, who, at);
    chk("grant_clear", who, 1);
    chk("gap_long", at - last_at, 1 + XFER + T_LONG);
    last_at = at;
    @(posedge clk); #1;
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h41;
    bus.REQ1_RS = 1'b1; bus.REQ1_DATA = 8'h42;
    for (int k = 0; k < 4; k++) push(1'b1, (k % 2 == 0) ? 8'h41 : 8'h42, -1);

    for (int k = 0; k < 4; k++) begin
      wait_ready(200, who, at);
      chk("grant_rr", who, k % 2);
      chk("gap_rr", at - last_at, 1 + XFER + T_CMD);
      last_at = at;
    end
    @(posedge clk); #1;
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.BUSY && sb.size() == 0) break;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", bus.BUSY, 0);

    // Reset in the middle of an E pulse.
    skip_width = 1'b1;
    bus.REQ0_VALID = 1'b1; bus.REQ0_RS = 1'b1; bus.REQ0_DATA = 8'h55;
    push(1'b1, 8'h55, -1);
    wait_ready(50, who, at);
    chk("grant_55", who, 0);
    @(posedge clk); #1;
    bus.REQ0_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.LCD_E) break;
    end
    chk("e_before_reset", bus.LCD_E, 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    skip_width = 1'b0;
    push_init();
    resetn = 1'b1;
    wait_init_done(at, early);
    chk("reinit_done_cycle", at, T_POWERON + 3 * (XFER + T_CMD) + XFER + T_LONG);
    chk("reinit_no_ready", {bus.REQ1_READY, bus.REQ0_READY}, 0);
    chk("reinit_sb", sb.size(), 0);
    chk("no_dual_ready", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/lcd_bus_sched.md
# lcd_bus_sched

Write-only command/data scheduler for the HD44780-style character LCD bus (LCD_E, LCD_RS, LCD_RW, LCD_DATA[7:0]). After reset it runs the LCD power-on init sequence on its own. It then arbitrates between two client requesters, for example a status-line writer and a message writer, and serialises each accepted byte into one correctly timed enable pulse followed by an execution wait. It sits between the display-content logic and the LCD pins and is the only driver of those pins.

## Interface
Parameters (all in CLK cycles, legal range 1..65535):
- T_POWERON, 15000: wait after reset release before the first init command.
- T_SU, 2: RS/DATA setup with E low, before E rises.
- T_EW, 4: E high width.
- T_H, 2: RS/DATA hold with E low, after E falls.
- T_CMD, 40: execution wait for ordinary commands and data.
- T_LONG, 1600: execution wait for clear/home (RS=0 and DATA[7:2]==0, DATA!=0).

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset; one clock; reset is synchronous and active-low.
- REQ0_VALID  in  1  requester 0 has a byte.
- REQ0_RS  in  1  requester 0 register select (0 = command, 1 = data).
- REQ0_DATA  in  8  requester 0 byte.
- REQ0_READY  out  1  one-cycle accept pulse to requester 0.
- REQ1_VALID / REQ1_RS / REQ1_DATA / REQ1_READY: same roles, requester 1.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  tied 0 after reset; the block never reads.
- LCD_DATA  out  8  bus data.
- INIT_DONE  out  1  high once the init sequence completes; stays high until reset.
- BUSY  out  1  high in every state except IDLE.

## Operation
- All outputs reset to: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0, REQx_READY=0, INIT_DONE=0, BUSY=1.
- States: PWR_WAIT, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, EXEC, ARB pointer register.
- PWR_WAIT lasts T_POWERON cycles.
- INIT_LOAD then issues four commands in order, each through the SETUP→E_HIGH→HOLD→EXEC path with RS=0:
  - 8'h3C (function set)
  - 8'h0C (display on)
  - 8'h06 (entry mode)
  - 8'h01 (clear; uses T_LONG)
- After the last EXEC, INIT_DONE rises and the state goes to IDLE.
- Handshake:
  - A requester holds VALID, RS and DATA stable until it sees READY.
  - READY is asserted only in IDLE with INIT_DONE=1, for exactly one cycle.
  - RS and DATA are captured on that same edge.
- Arbitration:
  - Two-way round-robin; the pointer records the last grant and resets to "1 last" (requester 0 wins first tie).
  - If one requester is valid, it is granted. If both are valid, the one not granted last wins.
  - At most one READY per cycle.
- Transfer:
  - SETUP: T_SU cycles, E=0, RS/DATA driven.
  - E_HIGH: T_EW cycles, E=1.
  - HOLD: T_H cycles, E=0, RS/DATA unchanged.
  - EXEC: T_CMD or T_LONG cycles.
  - Then IDLE.
- LCD_RS and LCD_DATA keep the last transferred values while IDLE.
- Requests during PWR_WAIT or init are not acknowledged. They remain pending and are served in order of arbitration after INIT_DONE.
- Reset asserted mid-transfer: on the next edge all outputs take their reset values and the full init sequence reruns. There is no partial E pulse beyond that edge.

## Timing
- Single 16-bit down-counter, loaded with (phase length − 1) on phase entry; the phase exits when the counter reaches 0.
- Accepted byte:
  - READY in cycle n.
  - E high in cycles n+1+T_SU .. n+T_SU+T_EW.
  - Earliest next READY is cycle n+1+T_SU+T_EW+T_H+Tx, where Tx is the selected EXEC length. With defaults: n+49 (ordinary) or n+1609 (long).
- Init: INIT_DONE goes high in cycle T_POWERON + 3·(T_SU+T_EW+T_H+T_CMD) + (T_SU+T_EW+T_H+T_LONG), counted from the first edge with RESETN=1. With defaults this is cycle 16752.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header lcd_pkg:
  - State encoding.
  - Init command constants LCD_FUNC_SET=8'h3C, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01.
  - Long-command decode function.
- Sub-module lcd_rr_arb: two-way round-robin grant with pointer update on accept. It is reused later if more requesters are added.

## Test plan
- Reset, then idle inputs → LCD_E stays 0 until the first init strobe. The bus shows 3C, 0C, 06, 01 with RS=0. INIT_DONE rises at cycle 16752.
- After init, REQ0 writes RS=1, DATA=8'h4B → READY0 pulses once; E high for 4 cycles with RS=1, DATA=4B; next READY no earlier than +49 cycles.
- Both requesters valid continuously with distinct bytes (0x41, 0x42) → grants alternate 0,1,0,1 starting with 0; no cycle has both READYs high.
- REQ1 sends RS=0, DATA=8'h01 → EXEC lasts 1600 cycles; next grant at +1609. RS=0, DATA=8'h80 → +49.
- REQ0_VALID held high from reset → no READY before INIT_DONE; accepted in the first IDLE cycle after init.
- RESETN pulled low during E_HIGH of a data write → next edge gives E=0, DATA=0, INIT_DONE=0, BUSY=1; after release the init sequence repeats with identical timing.
